// File: rtl/oam_dma_engine.sv
// oam_dma_engine: NES $4014 sprite DMA, copies one page of program memory
// into PPU OAM through the $2004 data port while stalling the CPU.
module oam_dma_engine #(
    parameter int          OAM_BYTES = 256,
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter bit          ALIGN_ODD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_odd,
    output logic        cpu_rdy,
    output logic        dma_busy,
    output logic        mem_cs,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        ppu_wr,
    output logic [2:0]  ppu_addr,
    output logic [7:0]  ppu_wdata
);
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    localparam logic [7:0] LAST = 8'(OAM_BYTES - 1);

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] wdata_q, wdata_d;
    logic       odd_q, odd_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            page_q  <= '0;
            wdata_q <= '0;
            odd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            wdata_q <= wdata_d;
            odd_q   <= odd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        wdata_d = wdata_q;
        odd_d   = odd_q;
        case (state_q)
            IDLE: begin
                if (cpu_wr && cpu_addr == TRIG_ADDR) begin
                    page_d  = cpu_wdata;
                    odd_d   = cpu_odd & ALIGN_ODD;
                    state_d = HALT;
                end
            end
            HALT:  state_d = odd_q ? ALIGN : READ;
            ALIGN: state_d = READ;
            READ:  state_d = WRITE;
            WRITE: begin
                wdata_d = mem_rdata;
                // idx stays within the page so the last address is {page,LAST}
                idx_d   = (idx_q == LAST) ? 8'h00 : idx_q + 8'h01;
                state_d = (idx_q == LAST) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dma_busy  = state_q != IDLE;
    assign cpu_rdy   = !dma_busy;
    assign mem_rd    = state_q == READ;
    assign mem_cs    = !mem_rd;
    assign mem_addr  = mem_rd ? {page_q, idx_q} : 16'h0000;
    assign ppu_wr    = state_q == WRITE;
    assign ppu_addr  = ppu_wr ? 3'h4 : 3'h0;
    assign ppu_wdata = ppu_wr ? mem_rdata : wdata_q;
endmodule

// File: tb/tb_oam_dma_engine.sv
// tb_oam_dma_engine: table-driven and randomized transfers checked against a
// memory-array reference and cycle-count rules for the sprite DMA engine.
module tb_oam_dma_engine;
    localparam int          N    = 256;
    localparam logic [15:0] TRIG = 16'h4014;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic        cpu_odd;
    logic        cpu_rdy, dma_busy, mem_cs, mem_rd, ppu_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [2:0]  ppu_addr;
    logic [7:0]  ppu_wdata;
    logic        cpu_rdy0, busy0, cs0, rd0, ppu_wr0;
    logic [15:0] addr0;
    logic [2:0]  ppu_addr0;
    logic [7:0]  ppu_wdata0;

    logic [7:0] mem [65536];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    oam_dma_engine #(.OAM_BYTES(N), .TRIG_ADDR(TRIG), .ALIGN_ODD(1'b1)) dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_odd(cpu_odd), .cpu_rdy(cpu_rdy), .dma_busy(dma_busy), .mem_cs(mem_cs),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .ppu_wr(ppu_wr),
        .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata)
    );

    // Second engine without odd-cycle alignment; only its busy length is checked.
    oam_dma_engine #(.OAM_BYTES(N), .TRIG_ADDR(TRIG), .ALIGN_ODD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_odd(cpu_odd), .cpu_rdy(cpu_rdy0), .dma_busy(busy0), .mem_cs(cs0),
        .mem_rd(rd0), .mem_addr(addr0), .mem_rdata(mem_rdata), .ppu_wr(ppu_wr0),
        .ppu_addr(ppu_addr0), .ppu_wdata(ppu_wdata0)
    );

    // Registered program memory: data appears the cycle after the read strobe.
    always @(posedge clk)
        if (!mem_cs && mem_rd) mem_rdata <= mem[mem_addr];

    typedef struct {
        logic [7:0] page;
        logic       odd;
        int         glitch;
        int         exp_busy;
        int         exp_first;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " cpu_rdy"}, 32'(cpu_rdy), 32'd1);
        chk({tag, " dma_busy"}, 32'(dma_busy), 32'd0);
        chk({tag, " mem_cs"}, 32'(mem_cs), 32'd1);
        chk({tag, " mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, " ppu_wr"}, 32'(ppu_wr), 32'd0);
        chk({tag, " ppu_addr"}, 32'(ppu_addr), 32'd0);
        chk({tag, " ppu_wdata"}, 32'(ppu_wdata), 32'd0);
    endtask

    // Entered and left at a negedge; the trigger is sampled at the next posedge.
    task automatic xfer(input vec_t v, input string tag);
        int busy_n = 0, busy0_n = 0, rd_i = 0, wr_i = 0, first = -1;
        logic prev_low = 1'b0;
        logic [15:0] last_rd = 16'h0;
        bit done = 0;
        cpu_addr = TRIG; cpu_wdata = v.page; cpu_odd = v.odd; cpu_wr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_wr = 1'b0; cpu_odd = 1'b0;
        for (int c = 1; c < 700 && !done; c++) begin
            if (dma_busy) busy_n++;
            if (busy0) busy0_n++;
            if (cpu_rdy !== !dma_busy) chk({tag, " cpu_rdy"}, 32'(cpu_rdy), 32'(!dma_busy));
            if (mem_rd !== !mem_cs) chk({tag, " rd_vs_cs"}, 32'(mem_rd), 32'(!mem_cs));
            if (!mem_cs) begin
                if (first < 0) first = c;
                chk($sformatf("%s consecutive_cs c%0d", tag, c), 32'(prev_low), 32'd0);
                chk($sformatf("%s mem_addr r%0d", tag, rd_i), 32'(mem_addr), 32'({v.page, 8'(rd_i)}));
                last_rd = mem_addr;
                rd_i++;
            end
            prev_low = !mem_cs;
            if (ppu_wr) begin
                chk({tag, " ppu_addr"}, 32'(ppu_addr), 32'h4);
                chk($sformatf("%s ppu_wdata w%0d", tag, wr_i), 32'(ppu_wdata),
                    32'(mem[{v.page, 8'(wr_i)}]));
                wr_i++;
            end
            if (c == v.glitch) begin
                cpu_addr = TRIG; cpu_wdata = ~v.page; cpu_wr = 1'b1;
            end else cpu_wr = 1'b0;
            if (!dma_busy && !busy0) done = 1;
            else @(negedge clk);
        end
        cpu_wr = 1'b0;
        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'(v.exp_busy));
        chk({tag, " busy_cycles_noalign"}, 32'(busy0_n), 32'(1 + 2 * N));
        chk({tag, " first_read"}, 32'(first), 32'(v.exp_first));
        chk({tag, " reads"}, 32'(rd_i), 32'(N));
        chk({tag, " writes"}, 32'(wr_i), 32'(N));
        chk({tag, " last_addr"}, 32'(last_rd), 32'({v.page, 8'hFF}));
    endtask

    vec_t vecs[$];

    initial begin
        int hits;
        bit found;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        vecs.push_back('{8'h02, 1'b0, 0,   513, 2});
        vecs.push_back('{8'h02, 1'b1, 0,   514, 3});
        vecs.push_back('{8'h80, 1'b0, 0,   513, 2});
        vecs.push_back('{8'h02, 1'b0, 100, 513, 2});
        vecs.push_back('{8'h30, 1'b1, 0,   514, 3});
        vecs.push_back('{8'hFF, 1'b0, 0,   513, 2});
        vecs.push_back('{8'h03, 1'b0, 0,   513, 2});

        rst = 1'b1; cpu_addr = 16'h0; cpu_wr = 1'b0; cpu_wdata = 8'h0; cpu_odd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset_held");
        rst = 1'b0;
        @(negedge clk);
        chk_reset("reset_released");

        cpu_addr = 16'h4015; cpu_wdata = 8'h02; cpu_wr = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0;
        chk("other_addr busy", 32'(dma_busy), 32'd0);
        @(negedge clk);
        chk("other_addr busy_later", 32'(dma_busy), 32'd0);

        // Consecutive calls trigger in the first idle cycle: back-to-back transfers.
        foreach (vecs[i]) xfer(vecs[i], $sformatf("vec%0d", i));

        cpu_addr = TRIG; cpu_wdata = 8'h02; cpu_odd = 1'b0; cpu_wr = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0;
        hits = 0;
        found = 0;
        for (int c = 0; c < 700 && !found; c++) begin
            if (ppu_wr) begin
                if (hits == 40) found = 1;
                hits++;
            end
            if (!found) @(negedge clk);
        end
        chk("rst_mid reached_byte40", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("rst_mid");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_mid quiet_cs", 32'(mem_cs), 32'd1);
            chk("rst_mid quiet_ppu", 32'(ppu_wr), 32'd0);
        end
        xfer('{8'h02, 1'b0, 0, 513, 2}, "restart");

        for (int k = 0; k < 6; k++) begin
            vec_t v;
            v.page = 8'($urandom);
            v.odd = 1'($urandom);
            v.glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 500)) : 0;
            v.exp_busy = 1 + int'(v.odd) + 2 * N;
            v.exp_first = 2 + int'(v.odd);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer(v, $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
